// File: rtl/arb_pkg.sv
// Shared arbitration types and one-hot helpers used by rr_lock_arbiter.
// Helpers work on ARB_MAX-wide vectors; callers zero-extend and truncate.
package arb_pkg;

  localparam int unsigned ARB_MAX = 32;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  function automatic int unsigned onehot_to_idx(input logic [ARB_MAX-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ARB_MAX; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // Mask of bits >= (idx+1) mod size; the holder in the top slot wraps to all-ones.
  function automatic logic [ARB_MAX-1:0] thermo_above(input logic [ARB_MAX-1:0] oh,
                                                      input int unsigned size);
    int unsigned idx;
    logic [ARB_MAX-1:0] mask;
    idx  = onehot_to_idx(oh);
    mask = '0;
    for (int unsigned i = 0; i < ARB_MAX; i++) begin
      if (i < size && (idx + 1 == size || i > idx)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/prio_arbiter_lsb_to_msb.sv
// Combinational fixed-priority pick: lowest set request bit wins.
module prio_arbiter_lsb_to_msb #(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0] req,
  output logic [SIZE-1:0] gnt
);

  always_comb begin : pick
    logic found;
    found = 1'b0;
    gnt   = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      gnt[i] = req[i] & ~found;
      found  = found | req[i];
    end
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking; the holder keeps the grant until it drops req.
// Define ARB_TIMEOUT_EN to add the MAX_HOLD hold counter, forced rotation and preempt pulse.
module rr_lock_arbiter #(
  parameter int unsigned SIZE     = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [SIZE-1:0]                             req,
  output logic [SIZE-1:0]                             gnt,
  output logic                                        gnt_valid,
  output logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0]  gnt_id,
  output logic                                        preempt
);
  import arb_pkg::*;

  localparam int unsigned ID_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  if (SIZE < 1 || SIZE > ARB_MAX || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_lock_arbiter: unsupported SIZE/MAX_HOLD");
  end

  arb_state_e      state;
  logic [SIZE-1:0] ptr;
  logic [SIZE-1:0] cand;
  logic [SIZE-1:0] pick_m;
  logic [SIZE-1:0] pick_u;
  logic [SIZE-1:0] win;
  logic            hold;
  logic            take;
  logic            drop;
  logic            rotate;
  logic            expired;

  // Excluding the holder is a no-op on release or in IDLE, and selects the
  // competitors on a timeout, so one candidate set serves every case.
  assign cand = req & ~gnt;
  assign hold = |(req & gnt);

  prio_arbiter_lsb_to_msb #(.SIZE(SIZE)) u_pick_masked (
    .req (cand & ptr),
    .gnt (pick_m)
  );

  prio_arbiter_lsb_to_msb #(.SIZE(SIZE)) u_pick_all (
    .req (cand),
    .gnt (pick_u)
  );

  assign win = (|pick_m) ? pick_m : pick_u;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned      CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] cnt;
  assign expired = (cnt == CNT_LAST);
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    take   = 1'b0;
    drop   = 1'b0;
    rotate = 1'b0;
    case (state)
      ARB_IDLE: take = |cand;
      ARB_GRANT: begin
        if (!hold) begin
          take = |cand;
          drop = ~|cand;
        end else if (expired && |cand) begin
          take   = 1'b1;
          rotate = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      preempt   <= 1'b0;
      ptr       <= '1;
`ifdef ARB_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      preempt <= rotate;
      if (take) begin
        state     <= ARB_GRANT;
        gnt       <= win;
        gnt_valid <= 1'b1;
        gnt_id    <= ID_W'(onehot_to_idx(ARB_MAX'(win)));
        ptr       <= SIZE'(thermo_above(ARB_MAX'(win), SIZE));
      end else if (drop) begin
        state     <= ARB_IDLE;
        gnt       <= '0;
        gnt_valid <= 1'b0;
        gnt_id    <= '0;
      end
`ifdef ARB_TIMEOUT_EN
      if (take) begin
        cnt <= '0;
      end else if (state == ARB_GRANT && !expired) begin
        cnt <= cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed and random checks for rr_lock_arbiter (SIZE=4, MAX_HOLD=4).
module tb_rr_lock_arbiter;

  localparam int unsigned SIZE = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  rr_lock_arbiter #(.SIZE(SIZE), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed/expected vectors are {gnt, gnt_valid, gnt_id, preempt}.
  task automatic test_reset();
    logic [7:0] obs;
    rst_n = 1'b0;
    req   = '0;
    #3;
    obs = {gnt, gnt_valid, gnt_id, preempt};
    checks++;
    if (obs !== 8'b0000_0_00_0) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", obs, 8'b0000_0_00_0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    obs = {gnt, gnt_valid, gnt_id, preempt};
    checks++;
    if (obs !== 8'b0000_0_00_0) begin
      errors++;
      $display("FAIL idle_after_reset got=%b want=%b", obs, 8'b0000_0_00_0);
    end
  endtask

  task automatic test_handoff();
    logic [7:0] obs;
    req = 4'b1010;
    tick();
    obs = {gnt, gnt_valid, gnt_id, preempt};
    checks++;
    if (obs !== {4'b0010, 1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL handoff_first got=%b want=%b", obs, {4'b0010, 1'b1, 2'd1, 1'b0});
    end
    req = 4'b1000;
    tick();
    obs = {gnt, gnt_valid, gnt_id, preempt};
    checks++;
    if (obs !== {4'b1000, 1'b1, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL handoff_no_bubble got=%b want=%b", obs, {4'b1000, 1'b1, 2'd3, 1'b0});
    end
    req = 4'b0000;
    tick();
    obs = {gnt, gnt_valid, gnt_id, preempt};
    checks++;
    if (obs !== 8'b0000_0_00_0) begin
      errors++;
      $display("FAIL handoff_to_idle got=%b want=%b", obs, 8'b0000_0_00_0);
    end
  endtask

  task automatic test_rotation();
    logic [5:0] obs;
    logic [5:0] exp;
    logic [3:0] e;
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      e   = 4'b0001 << (k % 4);
      exp = {e, 2'(k % 4)};
      obs = {gnt, gnt_id};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rotation_first[%0d] got=%b want=%b", k, obs, exp);
      end
      tick();
      obs = {gnt, gnt_id};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rotation_hold[%0d] got=%b want=%b", k, obs, exp);
      end
      req = 4'b1111 & ~e;
      tick();
      req = 4'b1111;
    end
    req = 4'b0000;
    tick();
    checks++;
    if ({gnt, gnt_valid} !== 5'b0000_0) begin
      errors++;
      $display("FAIL rotation_idle got=%b want=%b", {gnt, gnt_valid}, 5'b0000_0);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] obs;
    logic [7:0] exp;
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      obs = {gnt, gnt_valid, gnt_id, preempt};
      checks++;
      if (obs !== {4'b0001, 1'b1, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL timeout_alone[%0d] got=%b want=%b", c, obs, {4'b0001, 1'b1, 2'd0, 1'b0});
      end
    end
    req = 4'b0101;
    tick();
    obs = {gnt, gnt_valid, gnt_id, preempt};
    exp = TO_EN ? {4'b0100, 1'b1, 2'd2, 1'b1} : {4'b0001, 1'b1, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL timeout_preempt got=%b want=%b", obs, exp);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      obs = {gnt, gnt_valid, gnt_id, preempt};
      exp = TO_EN ? {4'b0100, 1'b1, 2'd2, 1'b0} : {4'b0001, 1'b1, 2'd0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL timeout_new_hold[%0d] got=%b want=%b", c, obs, exp);
      end
    end
    tick();
    obs = {gnt, gnt_valid, gnt_id, preempt};
    exp = TO_EN ? {4'b0001, 1'b1, 2'd0, 1'b1} : {4'b0001, 1'b1, 2'd0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL timeout_rotate_back got=%b want=%b", obs, exp);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
    end
    // Holder 0 sits at the hold limit (timeout build); dropping req now is a release.
    req = 4'b0100;
    tick();
    obs = {gnt, gnt_valid, gnt_id, preempt};
    checks++;
    if (obs !== {4'b0100, 1'b1, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL timeout_release_wins got=%b want=%b", obs, {4'b0100, 1'b1, 2'd2, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] obs;
    #2;
    rst_n = 1'b0;
    #1;
    obs = {gnt, gnt_valid, gnt_id, preempt};
    checks++;
    if (obs !== 8'b0000_0_00_0) begin
      errors++;
      $display("FAIL async_reset_drop got=%b want=%b", obs, 8'b0000_0_00_0);
    end
    req = 4'b0110;
    tick();
    rst_n = 1'b1;
    tick();
    obs = {gnt, gnt_valid, gnt_id, preempt};
    checks++;
    if (obs !== {4'b0010, 1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL ptr_after_reset got=%b want=%b", obs, {4'b0010, 1'b1, 2'd1, 1'b0});
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    logic [3:0]  nreq;
    logic [3:0]  prev_req;
    logic [3:0]  prev_gnt;
    int unsigned wait_cnt [4];
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      nreq = req;
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) nreq[i] = ($urandom_range(3) == 0);
        else if (gnt[i] && $urandom_range(2) == 0) nreq[i] = 1'b0;
      end
      req      = nreq;
      prev_req = nreq;
      prev_gnt = gnt;
      tick();
      checks++;
      if (!$onehot0(gnt)) begin
        errors++;
        $display("FAIL rand_onehot cycle=%0d got=%b want=one-hot or zero", c, gnt);
      end
      checks++;
      if ((gnt & ~prev_req) !== 4'b0000) begin
        errors++;
        $display("FAIL rand_subset cycle=%0d got=%b want subset of %b", c, gnt, prev_req);
      end
      checks++;
      if (gnt_valid !== (|gnt)) begin
        errors++;
        $display("FAIL rand_valid cycle=%0d got=%b want=%b", c, gnt_valid, |gnt);
      end
      if (gnt != prev_gnt && gnt != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (gnt[i]) begin
            wait_cnt[i] = 0;
          end else if (prev_req[i]) begin
            wait_cnt[i]++;
            checks++;
            if (wait_cnt[i] > SIZE) begin
              errors++;
              $display("FAIL rand_starve cycle=%0d req%0d waited=%0d want<=%0d", c, i, wait_cnt[i], SIZE);
            end
          end else begin
            wait_cnt[i] = 0;
          end
        end
      end
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_handoff();
    test_rotation();
    test_timeout();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
